// File: rtl/mips_mc_core.sv
// Multi-cycle core for the 16-bit MIPS-like ISA over an XLEN-wide datapath.
// Fetch and load/store share one req/ack memory port, so any number of wait states is tolerated.
module mips_mc_core #(
  parameter int              XLEN     = 16,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack,
  output logic [XLEN-1:0] pc_out,
  output logic [15:0]     instruction,
  output logic [XLEN-1:0] alu_result,
  output logic            retire,
  output logic            halted
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [2:0]      OP_R    = 3'd0;
  localparam logic [2:0]      OP_LW   = 3'd1;
  localparam logic [2:0]      OP_SW   = 3'd2;
  localparam logic [2:0]      OP_BEQ  = 3'd4;
  localparam logic [2:0]      OP_BNE  = 3'd5;
  localparam logic [2:0]      OP_J    = 3'd6;
  localparam logic [2:0]      OP_JAL  = 3'd7;
  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-2){1'b0}}, 2'b10};

  state_t          state_r;
  logic [XLEN-1:0] pc_r, alu_r, a_r, b_r, load_r;
  logic [15:0]     ir_r;
  logic            halted_r;
  logic [XLEN-1:0] regs_r [0:7];

  logic [2:0]      op_s, rs_s, rt_s, rd_s, dest_s;
  logic [3:0]      funct_s;
  logic [XLEN-1:0] imm_s, opb_s, alu_s, jump_s, branch_s, wb_data_s;
  logic            illegal_s, taken_s, ctl_only_s;

  assign op_s       = ir_r[15:13];
  assign rs_s       = ir_r[12:10];
  assign rt_s       = ir_r[9:7];
  assign rd_s       = ir_r[6:4];
  assign funct_s    = ir_r[3:0];
  assign imm_s      = {{(XLEN-7){ir_r[6]}}, ir_r[6:0]};
  assign jump_s     = {pc_r[XLEN-1:14], ir_r[12:0], 1'b0};
  assign branch_s   = pc_r + {imm_s[XLEN-2:0], 1'b0};
  assign illegal_s  = (op_s == OP_R) && (funct_s > 4'd4);
  assign taken_s    = ((op_s == OP_BEQ) && (a_r == b_r)) || ((op_s == OP_BNE) && (a_r != b_r));
  assign ctl_only_s = (op_s == OP_BEQ) || (op_s == OP_BNE) || (op_s == OP_J);

  // ALU: R-type by funct, address/immediate adds otherwise; JAL passes the return address
  always_comb begin
    opb_s = imm_s;
    alu_s = {XLEN{1'b0}};
    if ((op_s == OP_R) || (op_s == OP_BEQ) || (op_s == OP_BNE)) begin
      opb_s = b_r;
    end else begin
      opb_s = imm_s;
    end
    if (op_s == OP_R) begin
      case (funct_s)
        4'd0:    alu_s = a_r + b_r;
        4'd1:    alu_s = a_r - b_r;
        4'd2:    alu_s = a_r & b_r;
        4'd3:    alu_s = a_r | b_r;
        4'd4:    alu_s = {{(XLEN-1){1'b0}}, ($signed(a_r) < $signed(b_r))};
        default: alu_s = {XLEN{1'b0}};
      endcase
    end else if (op_s == OP_JAL) begin
      alu_s = pc_r;
    end else begin
      alu_s = a_r + opb_s;
    end
  end

  // Write-back destination and data selection
  always_comb begin
    dest_s    = rt_s;
    wb_data_s = alu_r;
    case (op_s)
      OP_R:    dest_s = rd_s;
      OP_JAL:  dest_s = 3'd7;
      default: dest_s = rt_s;
    endcase
    if (op_s == OP_LW) begin
      wb_data_s = load_r;
    end else begin
      wb_data_s = alu_r;
    end
  end

  // Port strobes decode straight from state so a zero-wait ack completes in one cycle;
  // gating with reset makes mem_req fall the instant reset rises.
  assign mem_req     = ~reset & ((state_r == FETCH) || (state_r == MEM));
  assign mem_we      = mem_req & (state_r == MEM) & (op_s == OP_SW);
  assign mem_addr    = (state_r == FETCH) ? pc_r : alu_r;
  assign mem_wdata   = b_r;
  assign retire      = ~reset & ((state_r == WB) || ((state_r == EXEC) && ctl_only_s) ||
                                 ((state_r == MEM) && (op_s == OP_SW) && mem_ack));
  assign pc_out      = pc_r;
  assign instruction = ir_r;
  assign alu_result  = alu_r;
  assign halted      = halted_r;

  // Main sequencer: one state per phase, memory phases wait for ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= FETCH;
      pc_r     <= RESET_PC;
      ir_r     <= 16'h0000;
      alu_r    <= {XLEN{1'b0}};
      a_r      <= {XLEN{1'b0}};
      b_r      <= {XLEN{1'b0}};
      load_r   <= {XLEN{1'b0}};
      halted_r <= 1'b0;
      for (int i = 0; i < 8; i++) regs_r[i] <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        FETCH: begin
          if (mem_ack) begin
            ir_r    <= mem_rdata[15:0];
            pc_r    <= pc_r + PC_STEP;
            state_r <= DECODE;
          end
        end
        DECODE: begin
          a_r <= regs_r[rs_s];
          b_r <= regs_r[rt_s];
          if (illegal_s) begin
            state_r  <= HALT;
            halted_r <= 1'b1;
          end else begin
            state_r <= EXEC;
          end
        end
        EXEC: begin
          alu_r <= alu_s;
          case (op_s)
            OP_BEQ, OP_BNE: begin
              if (taken_s) pc_r <= branch_s;
              state_r <= FETCH;
            end
            OP_J: begin
              pc_r    <= jump_s;
              state_r <= FETCH;
            end
            OP_JAL: begin
              pc_r    <= jump_s;
              state_r <= WB;
            end
            OP_LW, OP_SW: state_r <= MEM;
            default:      state_r <= WB;
          endcase
        end
        MEM: begin
          if (mem_ack) begin
            if (op_s == OP_LW) begin
              load_r  <= mem_rdata;
              state_r <= WB;
            end else begin
              state_r <= FETCH;
            end
          end
        end
        WB: begin
          if (dest_s != 3'd0) regs_r[dest_s] <= wb_data_s;
          state_r <= FETCH;
        end
        HALT:    state_r <= HALT;
        default: state_r <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mc_core.sv
// Bench for mips_mc_core: runs a table-driven program against a wait-state memory model,
// scoreboarding every retired instruction, then covers halt and asynchronous reset.
module tb_mips_mc_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ack, retire, halted;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, pc_out, instruction, alu_result;

  mips_mc_core #(.XLEN(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .pc_out(pc_out),
    .instruction(instruction), .alu_result(alu_result), .retire(retire), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] instr;
    logic        chk_alu;
    logic [15:0] alu;
    logic [15:0] next_pc;
    int          cycles;
    int          fw;
    int          dw;
    logic        chk_wr;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
  } vec_t;

  localparam int N = 20;
  vec_t        tab [N];
  vec_t        q [$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_retired = 0;

  // Memory model: per-transfer wait states, fetch vs data chosen by bench-side tracking
  logic [15:0] mem [0:511];
  logic [15:0] poke_addr = 16'h0000;
  logic [15:0] poke_data = 16'h0000;
  int          fw_cfg = 0;
  int          dw_cfg = 0;
  int          wcnt = 0;
  logic        ack_en = 1'b1;
  logic        fetch_next = 1'b1;

  assign mem_rdata = (mem_addr == poke_addr) ? poke_data : mem[mem_addr[9:1]];
  assign mem_ack   = mem_req && ack_en && (wcnt >= (fetch_next ? fw_cfg : dw_cfg));

  always @(posedge clk) begin
    if (!mem_req || mem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
    mem[poke_addr[9:1]] <= poke_data;
    if (mem_req && mem_ack && mem_we) mem[mem_addr[9:1]] <= mem_wdata;
    if (reset) fetch_next <= 1'b1;
    else if (retire) fetch_next <= 1'b1;
    else if (mem_req && mem_ack && !mem_we) fetch_next <= 1'b0;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] rtype(input logic [2:0] rs, input logic [2:0] rt,
                                        input logic [2:0] rd, input logic [3:0] f);
    return {3'b000, rs, rt, rd, f};
  endfunction

  function automatic logic [15:0] itype(input logic [2:0] op, input logic [2:0] rs,
                                        input logic [2:0] rt, input logic [6:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [15:0] jtype(input logic [2:0] op, input logic [12:0] t);
    return {op, t};
  endfunction

  function automatic vec_t mk(input logic [15:0] a, input logic [15:0] i, input logic ca,
                              input logic [15:0] al, input logic [15:0] np, input int c,
                              input int f, input int d, input logic cw,
                              input logic [15:0] wa, input logic [15:0] wd);
    vec_t v;
    v.addr = a; v.instr = i; v.chk_alu = ca; v.alu = al; v.next_pc = np; v.cycles = c;
    v.fw = f; v.dw = d; v.chk_wr = cw; v.wr_addr = wa; v.wr_data = wd;
    return v;
  endfunction

  // Monitor: sampled on the falling edge, pops the scoreboard on every retire
  initial begin
    int          cyc;
    logic        prev_wait;
    logic [15:0] prev_addr;
    logic [15:0] exp_fetch;
    vec_t        e;
    cyc = 0; prev_wait = 1'b0; prev_addr = 16'h0000; exp_fetch = 16'h0000;
    forever begin
      @(negedge clk);
      if (reset) begin
        cyc = 0; prev_wait = 1'b0; exp_fetch = 16'h0000;
      end else begin
        cyc++;
        if (prev_wait) begin
          check("hold_req", {15'd0, mem_req}, 16'h0001);
          check("hold_addr", mem_addr, prev_addr);
        end
        prev_wait = mem_req && !mem_ack;
        prev_addr = mem_addr;
        if (fetch_next && mem_req && !mem_we && mem_ack) check("fetch_addr", mem_addr, exp_fetch);
        if (mem_req && mem_we && mem_ack) begin
          if (q.size() == 0 || !q[0].chk_wr) begin
            check("unexpected_write", 16'h0001, 16'h0000);
          end else begin
            check("wr_addr", mem_addr, q[0].wr_addr);
            check("wr_data", mem_wdata, q[0].wr_data);
          end
        end
        if (retire) begin
          if (q.size() == 0) begin
            check("unexpected_retire", instruction, 16'hxxxx);
          end else begin
            e = q.pop_front();
            check("instr", instruction, e.instr);
            check("cycles", 16'(cyc), 16'(e.cycles));
            if (e.chk_alu) check("alu_result", alu_result, e.alu);
            exp_fetch = e.next_pc;
          end
          n_retired++;
          cyc = 0;
        end
      end
    end
  end

  task automatic wait_retired(input int k, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (n_retired >= k) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!ok) check("retire_timeout", 16'(n_retired), 16'(k));
  endtask

  task automatic load_entry(input vec_t v);
    poke_addr = v.addr;
    poke_data = v.instr;
    fw_cfg    = v.fw;
    dw_cfg    = v.dw;
    q.push_back(v);
  endtask

  // Driver: program table, then halt and reset corner cases
  initial begin
    bit ok;
    ok = 1'b1;
    tab[0]  = mk(16'h0000, itype(3'd3, 3'd0, 3'd1, 7'h05), 1'b1, 16'h0005, 16'h0002, 4, 0, 0, 1'b0, 16'h0, 16'h0);
    tab[1]  = mk(16'h0002, itype(3'd3, 3'd0, 3'd2, 7'h7D), 1'b1, 16'hFFFD, 16'h0004, 4, 0, 0, 1'b0, 16'h0, 16'h0);
    tab[2]  = mk(16'h0004, rtype(3'd1, 3'd2, 3'd3, 4'd0),  1'b1, 16'h0002, 16'h0006, 4, 0, 0, 1'b0, 16'h0, 16'h0);
    tab[3]  = mk(16'h0006, rtype(3'd1, 3'd2, 3'd3, 4'd1),  1'b1, 16'h0008, 16'h0008, 4, 0, 0, 1'b0, 16'h0, 16'h0);
    tab[4]  = mk(16'h0008, rtype(3'd1, 3'd2, 3'd3, 4'd2),  1'b1, 16'h0005, 16'h000A, 4, 0, 0, 1'b0, 16'h0, 16'h0);
    tab[5]  = mk(16'h000A, rtype(3'd1, 3'd2, 3'd3, 4'd3),  1'b1, 16'hFFFD, 16'h000C, 4, 0, 0, 1'b0, 16'h0, 16'h0);
    tab[6]  = mk(16'h000C, rtype(3'd2, 3'd1, 3'd3, 4'd4),  1'b1, 16'h0001, 16'h000E, 4, 0, 0, 1'b0, 16'h0, 16'h0);
    tab[7]  = mk(16'h000E, rtype(3'd1, 3'd1, 3'd0, 4'd0),  1'b1, 16'h000A, 16'h0010, 4, 0, 0, 1'b0, 16'h0, 16'h0);
    tab[8]  = mk(16'h0010, itype(3'd4, 3'd1, 3'd1, 7'h7F), 1'b0, 16'h0000, 16'h0010, 3, 0, 0, 1'b0, 16'h0, 16'h0);
    tab[9]  = mk(16'h0010, itype(3'd5, 3'd1, 3'd1, 7'h04), 1'b0, 16'h0000, 16'h0012, 3, 0, 0, 1'b0, 16'h0, 16'h0);
    tab[10] = mk(16'h0012, rtype(3'd0, 3'd0, 3'd3, 4'd0),  1'b1, 16'h0000, 16'h0014, 4, 0, 0, 1'b0, 16'h0, 16'h0);
    tab[11] = mk(16'h0014, itype(3'd2, 3'd0, 3'd1, 7'h02), 1'b1, 16'h0002, 16'h0016, 7, 0, 3, 1'b1, 16'h0002, 16'h0005);
    tab[12] = mk(16'h0016, itype(3'd1, 3'd0, 3'd4, 7'h02), 1'b1, 16'h0002, 16'h0018, 11, 3, 3, 1'b0, 16'h0, 16'h0);
    tab[13] = mk(16'h0018, rtype(3'd4, 3'd0, 3'd5, 4'd0),  1'b1, 16'h0005, 16'h001A, 4, 0, 0, 1'b0, 16'h0, 16'h0);
    tab[14] = mk(16'h001A, jtype(3'd6, 13'h0010),          1'b0, 16'h0000, 16'h0020, 3, 0, 0, 1'b0, 16'h0, 16'h0);
    tab[15] = mk(16'h0020, itype(3'd5, 3'd1, 3'd2, 7'h04), 1'b0, 16'h0000, 16'h002A, 3, 0, 0, 1'b0, 16'h0, 16'h0);
    tab[16] = mk(16'h002A, jtype(3'd6, 13'h0020),          1'b0, 16'h0000, 16'h0040, 3, 0, 0, 1'b0, 16'h0, 16'h0);
    tab[17] = mk(16'h0040, jtype(3'd7, 13'h0100),          1'b1, 16'h0042, 16'h0200, 4, 0, 0, 1'b0, 16'h0, 16'h0);
    tab[18] = mk(16'h0200, rtype(3'd7, 3'd0, 3'd6, 4'd0),  1'b1, 16'h0042, 16'h0202, 4, 0, 0, 1'b0, 16'h0, 16'h0);
    tab[19] = mk(16'h0202, jtype(3'd6, 13'h0021),          1'b0, 16'h0000, 16'h0042, 3, 0, 0, 1'b0, 16'h0, 16'h0);

    load_entry(tab[0]);
    repeat (3) @(posedge clk);
    #1;
    check("rst_pc", pc_out, 16'h0000);
    check("rst_instr", instruction, 16'h0000);
    check("rst_alu", alu_result, 16'h0000);
    check("rst_req_ret_halt", {13'd0, mem_req, retire, halted}, 16'h0000);
    reset = 1'b0;

    for (int k = 1; k < N && ok; k++) begin
      wait_retired(k, ok);
      if (ok) begin
        @(posedge clk);
        #1;
        load_entry(tab[k]);
      end
    end

    if (ok) wait_retired(N, ok);
    if (ok) begin
      // Illegal R-type funct at the J 0x21 target: must halt without retiring
      @(posedge clk);
      #1;
      poke_addr = 16'h0042;
      poke_data = rtype(3'd0, 3'd0, 3'd0, 4'hF);
      fw_cfg    = 0;
      repeat (6) @(negedge clk);
      check("halted", {15'd0, halted}, 16'h0001);
      check("halt_req", {15'd0, mem_req}, 16'h0000);
      check("halt_pc", pc_out, 16'h0044);
      check("halt_instr", instruction, 16'h000F);
      check("halt_no_retire", 16'(n_retired), 16'(N));
      repeat (10) @(negedge clk);
      check("halt_pc_frozen", pc_out, 16'h0044);
      check("halt_sticky", {15'd0, halted}, 16'h0001);

      // Reset clears halt; then a second reset lands in the middle of a stalled fetch
      @(posedge clk);
      #1;
      ack_en = 1'b0;
      reset  = 1'b1;
      #1;
      check("rst2_halted", {15'd0, halted}, 16'h0000);
      check("rst2_pc", pc_out, 16'h0000);
      check("rst2_alu", alu_result, 16'h0000);
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("wait_req", {15'd0, mem_req}, 16'h0001);
      check("wait_addr", mem_addr, 16'h0000);
      check("wait_we", {15'd0, mem_we}, 16'h0000);
      #2;
      reset = 1'b1;
      #1;
      check("async_req_drop", {15'd0, mem_req}, 16'h0000);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("post_rst_pc", pc_out, 16'h0000);
      check("post_rst_halted", {15'd0, halted}, 16'h0000);
      check("post_rst_instr", instruction, 16'h0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
